// File: rtl/b_feedback_pkg.sv
// b_feedback_pkg: shared token width, encodings, FSM states and token builder
package b_feedback_pkg;
  localparam int TOKEN_W = 33;
  localparam logic [TOKEN_W-1:0] TOKEN_COMMIT = '0;
  typedef enum logic {IDLE, WAIT} state_t;
  // A redirect to PC 0 forces bit 32 so it never collides with the commit token
  function automatic logic [TOKEN_W-1:0] make_token(input logic mispredict, input logic taken, input logic [31:0] pc);
    return mispredict ? {taken | ~|pc, pc} : TOKEN_COMMIT;
  endfunction
endpackage

// File: rtl/b_feedback_tx_if.sv
// b_feedback_tx_if: execute-side input and 2-phase feedback handshake signals
interface b_feedback_tx_if;
  import b_feedback_pkg::*;
  logic valid;
  logic mispredict;
  logic taken;
  logic [31:0] correct_pc;
  logic ready;
  logic drive_back;
  logic [TOKEN_W-1:0] data_back;
  logic free_back;
  logic overflow;
  modport master(input valid, mispredict, taken, correct_pc, free_back, output ready, drive_back, data_back, overflow);
  modport slave(output valid, mispredict, taken, correct_pc, free_back, input ready, drive_back, data_back, overflow);
endinterface

// File: rtl/b_feedback_fifo.sv
// b_feedback_fifo: power-of-two synchronous FIFO with head view and occupancy count
module b_feedback_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 33
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  assign head = mem[rd];
  // storage needs no reset; only pointers and count define validity
  always_ff @(posedge clk) if (push) mem[wr] <= din;
  // pointers wrap naturally at DEPTH; push+pop together leaves count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      rd <= rd + AW'(pop);
      wr <= wr + AW'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/b_feedback_tx.sv
// b_feedback_tx: queues resolved-branch tokens and sends them over a 2-phase drive/free handshake
module b_feedback_tx
  import b_feedback_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  b_feedback_tx_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_n;
  logic [AW:0] count;
  logic [TOKEN_W-1:0] head;
  logic [SYNC_STAGES-1:0] sync_q;
  logic free_sync, push, pop;
  assign bus.ready = count != (AW+1)'(DEPTH);
  assign push = bus.valid & bus.ready;
  assign pop = state == IDLE && count != '0;
  assign free_sync = sync_q[SYNC_STAGES-1];
  b_feedback_fifo #(.DEPTH(DEPTH), .W(TOKEN_W)) fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(make_token(bus.mispredict, bus.taken, bus.correct_pc)),
    .head(head),
    .count(count)
  );
  // bring the receiver's free toggle into this clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else begin
      sync_q[0] <= bus.free_back;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  // dropped pushes are remembered until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.overflow <= 1'b0;
    else if (bus.valid & ~bus.ready) bus.overflow <= 1'b1;
  end
  // one token outstanding: wait until the acknowledge phase catches up with drive
  always_comb state_n = state == IDLE ? (pop ? WAIT : IDLE) : (free_sync == bus.drive_back ? IDLE : WAIT);
  // launching a token loads data, flips drive and pops the FIFO on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bus.drive_back <= 1'b0;
      bus.data_back <= TOKEN_COMMIT;
    end else begin
      state <= state_n;
      if (pop) begin
        bus.drive_back <= ~bus.drive_back;
        bus.data_back <= head;
      end
    end
  end
endmodule

// File: tb/tb_b_feedback_tx.sv
// tb_b_feedback_tx: directed checks of token encoding, handshake timing, overflow, reset and ordering
module tb_b_feedback_tx;
  import b_feedback_pkg::*;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t [3];
  logic ph = 0;
  logic [32:0] last_tok = '0;
  b_feedback_tx_if bf();
  b_feedback_tx #(.DEPTH(4), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bf));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input logic m, input logic tk, input logic [31:0] pc);
    bf.valid = 1;
    bf.mispredict = m;
    bf.taken = tk;
    bf.correct_pc = pc;
    tick(1);
    bf.valid = 0;
  endtask
  task automatic expect_tok(input string tag, input logic [32:0] tok);
    int n = 0;
    ph = ~ph;
    while (bf.drive_back !== ph && n < 40) begin
      check({tag, " hold"}, bf.data_back, last_tok);
      tick(1);
      n++;
    end
    check({tag, " drv"}, bf.drive_back, ph);
    check({tag, " dat"}, bf.data_back, tok);
    last_tok = tok;
  endtask
  task automatic ack();
    bf.free_back = ph;
    tick(3);
  endtask
  initial begin
    bf.valid = 0;
    bf.mispredict = 0;
    bf.taken = 0;
    bf.correct_pc = '0;
    bf.free_back = 0;
    tick(3);
    check("rst drive", bf.drive_back, 0);
    check("rst data", bf.data_back, 0);
    check("rst ovf", bf.overflow, 0);
    check("rst ready", bf.ready, 1);
    rst = 0;
    tick(1);
    push(1, 1, 32'h0000_1040);
    check("t1 latency", bf.drive_back, 0);
    expect_tok("t1", 33'h1_0000_1040);
    tick(3);
    check("t1 held drv", bf.drive_back, 1);
    check("t1 held dat", bf.data_back, 33'h1_0000_1040);
    check("t1 held st", 33'(dut.state), 33'(WAIT));
    bf.free_back = 1;
    tick(2);
    check("t1 sync st", 33'(dut.state), 33'(WAIT));
    tick(1);
    check("t1 idle st", 33'(dut.state), 33'(IDLE));
    push(0, 0, 32'hdead_beef);
    expect_tok("t2 commit", 33'h0);
    ack();
    push(1, 0, 32'h0);
    expect_tok("t2 pc0", 33'h1_0000_0000);
    ack();
    push(1, 1, 32'h0000_0100);
    push(1, 0, 32'h0000_0200);
    push(1, 1, 32'h0000_0300);
    push(1, 0, 32'h0000_0400);
    push(0, 1, 32'h0000_0500);
    check("t3 full", bf.ready, 0);
    check("t3 no ovf", bf.overflow, 0);
    push(1, 1, 32'h0000_0600);
    check("t3 ovf", bf.overflow, 1);
    expect_tok("t3 a", 33'h1_0000_0100);
    ack();
    expect_tok("t3 b", 33'h0_0000_0200);
    ack();
    expect_tok("t3 c", 33'h1_0000_0300);
    ack();
    expect_tok("t3 d", 33'h0_0000_0400);
    ack();
    expect_tok("t3 e", 33'h0);
    ack();
    tick(8);
    check("t3 dropped", bf.drive_back, ph);
    check("t3 empty", bf.ready, 1);
    check("t3 ovf sticky", bf.overflow, 1);
    push(1, 1, 32'h0000_0a00);
    push(1, 0, 32'h0000_0b00);
    push(1, 1, 32'h0000_0c00);
    expect_tok("t4 a", 33'h1_0000_0a00);
    t[0] = cyc;
    bf.free_back = ph;
    expect_tok("t4 b", 33'h0_0000_0b00);
    t[1] = cyc;
    bf.free_back = ph;
    expect_tok("t4 c", 33'h1_0000_0c00);
    t[2] = cyc;
    bf.free_back = ph;
    check("t4 gap1", 33'(t[1] - t[0]), 4);
    check("t4 gap2", 33'(t[2] - t[1]), 4);
    tick(3);
    push(1, 1, 32'h0000_3000);
    push(1, 1, 32'h0000_3100);
    push(1, 1, 32'h0000_3200);
    tick(1);
    check("t5 wait st", 33'(dut.state), 33'(WAIT));
    #3 rst = 1;
    #1;
    check("t5 drive", bf.drive_back, 0);
    check("t5 data", bf.data_back, 0);
    check("t5 ready", bf.ready, 1);
    check("t5 ovf", bf.overflow, 0);
    bf.free_back = 0;
    ph = 0;
    last_tok = '0;
    tick(1);
    rst = 0;
    tick(1);
    push(1, 1, 32'h0000_4444);
    expect_tok("t5 new", 33'h1_0000_4444);
    ack();
    tick(6);
    check("t5 discarded", bf.drive_back, ph);
    bf.free_back = ~ph;
    tick(6);
    check("t6 spur drv", bf.drive_back, ph);
    check("t6 spur st", 33'(dut.state), 33'(IDLE));
    check("t6 spur rdy", bf.ready, 1);
    bf.free_back = ph;
    tick(4);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] pa;
      pa = 32'h0000_2000 + 32'(i * 8);
      push(1, 0, pa);
      push(1, 1, pa + 32'd4);
      expect_tok("t6 wrap a", {1'b0, pa});
      ack();
      expect_tok("t6 wrap b", {1'b1, pa + 32'd4});
      ack();
    end
    check("t6 end rdy", bf.ready, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
